// File: rtl/brief_pkg.sv
// Shared definitions for the BRIEF descriptor packer.
//
// Contents:
//   DESC_BITS_DEF / ID_W_DEF : default descriptor and keypoint-ID widths
//   desc_t                   : descriptor vector at the default width
//   asm_state_e              : assembly FSM states (FILL, HOLD)
//   popcount8                : number of ones in one test-result byte
package brief_pkg;

  localparam int DESC_BITS_DEF = 256;
  localparam int ID_W_DEF      = 16;

  typedef logic [DESC_BITS_DEF-1:0] desc_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } asm_state_e;

  // Ones count of a single byte; the packer adds one of these per beat
  // so the descriptor weight never needs a full-width adder tree.
  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, b[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/brief_desc_outreg.sv
// Output holding register for completed descriptors.
//
// Holds one descriptor and its keypoint ID (and weight when the
// DESC_WEIGHT_EN macro is defined) and presents it on a valid/ready pair.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   load_i      : capture data_i/id_i(/weight_i) this cycle
//   data_i/id_i : descriptor and keypoint ID to capture
//   weight_i    : descriptor popcount (DESC_WEIGHT_EN only)
//   ready_i     : consumer takes the held descriptor
//   valid_o     : a descriptor is held
//   data_o/id_o : held descriptor and keypoint ID
//   weight_o    : held popcount (DESC_WEIGHT_EN only)
//   free_o      : register can accept a load this cycle
module brief_desc_outreg #(
  parameter int DW = 256,
  parameter int IW = 16
`ifdef DESC_WEIGHT_EN
  ,
  parameter int WW = 9
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [IW-1:0] id_i,
`ifdef DESC_WEIGHT_EN
  input  logic [WW-1:0] weight_i,
  output logic [WW-1:0] weight_o,
`endif
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [IW-1:0] id_o,
  output logic          free_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [IW-1:0] id_q;
`ifdef DESC_WEIGHT_EN
  logic [WW-1:0] weight_q;
`endif

  // A held descriptor is being drained this cycle, or nothing is held,
  // so a new one may be loaded on the same edge.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign id_o    = id_q;
`ifdef DESC_WEIGHT_EN
  assign weight_o = weight_q;
`endif

  // Payload only changes on a load, which the top issues only when the
  // register is free, so it stays stable while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      id_q     <= '0;
`ifdef DESC_WEIGHT_EN
      weight_q <= '0;
`endif
    end else begin
      if (load_i) begin
        valid_q  <= 1'b1;
        data_q   <= data_i;
        id_q     <= id_i;
`ifdef DESC_WEIGHT_EN
        weight_q <= weight_i;
`endif
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/brief_desc_packer.sv
// Packs 8-bit BRIEF test-result beats into a DESC_BITS-wide descriptor
// tagged with a keypoint ID, double-buffered behind an output register.
//
// Optional feature macro: DESC_WEIGHT_EN adds a running popcount and the
// desc_weight output.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : byte handshake; in_bits bit 7 is the first test
//   in_kp_id              : keypoint ID, sampled on beat 0
//   in_abort              : drop the partial descriptor (FILL only)
//   desc_valid/desc_ready : descriptor handshake
//   desc_data, desc_kp_id : descriptor and its keypoint ID
//   desc_weight           : popcount of desc_data (DESC_WEIGHT_EN only)
module brief_desc_packer
  import brief_pkg::*;
#(
  parameter int DESC_BITS = DESC_BITS_DEF,
  parameter int ID_W      = ID_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_bits,
  input  logic [ID_W-1:0]              in_kp_id,
  input  logic                         in_abort,
  output logic                         desc_valid,
  input  logic                         desc_ready,
  output logic [DESC_BITS-1:0]         desc_data,
  output logic [ID_W-1:0]              desc_kp_id
`ifdef DESC_WEIGHT_EN
  ,
  output logic [$clog2(DESC_BITS+1)-1:0] desc_weight
`endif
);

  localparam int BEATS = DESC_BITS / 8;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W = $clog2(DESC_BITS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
`ifdef DESC_WEIGHT_EN
  localparam int WGT_W = $clog2(DESC_BITS + 1);
`endif

  asm_state_e           state_q;
  logic [CNT_W-1:0]     beatCnt_q, beatCnt_d;
  logic [DESC_BITS-1:0] asm_q, asm_d;
  logic [ID_W-1:0]      asmId_q, asmId_d;
`ifdef DESC_WEIGHT_EN
  logic [WGT_W-1:0]     weight_q, weight_d;
`endif
  logic [IDX_W-1:0]     sliceLsb;
  logic                 accept, lastBeat, outFree, transfer;

  assign in_ready = (state_q == FILL);
  assign accept   = in_valid && (state_q == FILL) && !in_abort;
  assign lastBeat = accept && (beatCnt_q == LAST_BEAT);
  assign transfer = (lastBeat || (state_q == HOLD)) && outFree;

  // Beat k occupies asm[DESC_BITS-1-8k -: 8], i.e. its LSB sits at
  // DESC_BITS-8-8k, so the first test of the descriptor becomes the MSB.
  assign sliceLsb = IDX_W'(DESC_BITS - 8) - IDX_W'({beatCnt_q, 3'b000});

  // Next assembly contents. asm_d already includes the beat accepted
  // this cycle, so a completing descriptor can go straight to the output
  // register on the same edge. In HOLD nothing changes and asm_d is the
  // completed descriptor awaiting transfer.
  always_comb begin
    beatCnt_d = beatCnt_q;
    asm_d     = asm_q;
    asmId_d   = asmId_q;
`ifdef DESC_WEIGHT_EN
    weight_d  = weight_q;
`endif
    if (state_q == FILL) begin
      if (in_abort) begin
        beatCnt_d = '0;
        asm_d     = '0;
`ifdef DESC_WEIGHT_EN
        weight_d  = '0;
`endif
      end else if (accept) begin
        if (beatCnt_q == '0) begin
          asm_d    = '0;
          asmId_d  = in_kp_id;
`ifdef DESC_WEIGHT_EN
          weight_d = '0;
`endif
        end
        asm_d[sliceLsb +: 8] = in_bits;
`ifdef DESC_WEIGHT_EN
        weight_d = weight_d + WGT_W'(popcount8(in_bits));
`endif
        beatCnt_d = lastBeat ? '0 : beatCnt_q + 1'b1;
      end
    end
  end

  // Assembly state machine and accumulators. A completed descriptor that
  // cannot move into a busy output register parks in HOLD, which closes
  // in_ready until the output register frees up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      beatCnt_q <= '0;
      asm_q     <= '0;
      asmId_q   <= '0;
`ifdef DESC_WEIGHT_EN
      weight_q  <= '0;
`endif
    end else begin
      beatCnt_q <= beatCnt_d;
      asm_q     <= asm_d;
      asmId_q   <= asmId_d;
`ifdef DESC_WEIGHT_EN
      weight_q  <= weight_d;
`endif
      case (state_q)
        FILL:    if (lastBeat && !outFree) state_q <= HOLD;
        HOLD:    if (outFree) state_q <= FILL;
        default: state_q <= FILL;
      endcase
    end
  end

  brief_desc_outreg #(
    .DW(DESC_BITS),
    .IW(ID_W)
`ifdef DESC_WEIGHT_EN
    ,
    .WW(WGT_W)
`endif
  ) u_outreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (transfer),
    .data_i   (asm_d),
    .id_i     (asmId_d),
`ifdef DESC_WEIGHT_EN
    .weight_i (weight_d),
    .weight_o (desc_weight),
`endif
    .ready_i  (desc_ready),
    .valid_o  (desc_valid),
    .data_o   (desc_data),
    .id_o     (desc_kp_id),
    .free_o   (outFree)
  );

endmodule

// File: tb/tb_brief_desc_packer.sv
// Self-checking bench for brief_desc_packer at DESC_BITS=256, ID_W=16.
// Weight checks are active when DESC_WEIGHT_EN is defined.
module tb_brief_desc_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_bits;
  logic [15:0]  in_kp_id;
  logic         in_abort;
  logic         desc_valid;
  logic         desc_ready;
  logic [255:0] desc_data;
  logic [15:0]  desc_kp_id;
`ifdef DESC_WEIGHT_EN
  logic [8:0]   desc_weight;
`endif

  int vecCount = 0;
  int errCount = 0;

  typedef struct {
    string       name;
    logic [7:0]  base;
    logic [7:0]  step;
    logic [15:0] kpId;
    logic [7:0]  expFirst;
    logic [7:0]  expLast;
    int          expWeight;
  } vec_t;

  vec_t vecs[4];

  brief_desc_packer #(.DESC_BITS(256), .ID_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bits     (in_bits),
    .in_kp_id    (in_kp_id),
    .in_abort    (in_abort),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_data   (desc_data),
`ifdef DESC_WEIGHT_EN
    .desc_weight (desc_weight),
`endif
    .desc_kp_id  (desc_kp_id)
  );

  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act,
                             input logic [255:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference descriptor: beat k carries base + step*k, beat 0 at the MSB.
  function automatic logic [255:0] buildDesc(input logic [7:0] base,
                                             input logic [7:0] step);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 32; k++) begin
      d[255-8*k -: 8] = base + 8'(int'(step) * k);
    end
    return d;
  endfunction

  task automatic checkWeight(input string name, input int exp);
`ifdef DESC_WEIGHT_EN
    checkOutput(name, 256'(desc_weight), 256'(exp));
`endif
  endtask

  // Present one byte and hold it until accepted, with a bounded wait.
  task automatic applyStimulus(input logic [7:0] b, input logic [15:0] id);
    int waitCnt;
    waitCnt  = 0;
    in_valid = 1'b1;
    in_bits  = b;
    in_kp_id = id;
    while (!in_ready && waitCnt < 200) begin
      tick();
      waitCnt++;
    end
    if (!in_ready) checkOutput("beat_accept_timeout", 256'(in_ready), 256'(1));
    tick();
  endtask

  task automatic sendDescriptor(input logic [7:0] base, input logic [7:0] step,
                                input logic [15:0] id);
    for (int k = 0; k < 32; k++) begin
      applyStimulus(base + 8'(int'(step) * k), id);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [255:0] descA, descB;

    vecs[0] = '{"stream_index", 8'h00, 8'h01, 16'h0042, 8'h00, 8'h1F, 80};
    vecs[1] = '{"all_80",       8'h80, 8'h00, 16'h1234, 8'h80, 8'h80, 32};
    vecs[2] = '{"all_ff",       8'hFF, 8'h00, 16'hFFFF, 8'hFF, 8'hFF, 256};
    vecs[3] = '{"odd_ramp",     8'h01, 8'h02, 16'hA5A5, 8'h01, 8'h3F, 112};

    rst_n = 1'b0; in_valid = 1'b0; in_bits = '0; in_kp_id = '0;
    in_abort = 1'b0; desc_ready = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_desc_valid", 256'(desc_valid), 256'(0));
    checkOutput("rst_desc_data", desc_data, 256'(0));
    checkOutput("rst_desc_kp_id", 256'(desc_kp_id), 256'(0));
    checkWeight("rst_desc_weight", 0);
    checkOutput("rst_in_ready", 256'(in_ready), 256'(1));
    rst_n = 1'b1;

    // Table-driven streaming descriptors
    desc_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      sendDescriptor(vecs[v].base, vecs[v].step, vecs[v].kpId);
      checkOutput({vecs[v].name, "_valid"}, 256'(desc_valid), 256'(1));
      checkOutput({vecs[v].name, "_data"}, desc_data,
                  buildDesc(vecs[v].base, vecs[v].step));
      checkOutput({vecs[v].name, "_first"}, 256'(desc_data[255:248]),
                  256'(vecs[v].expFirst));
      checkOutput({vecs[v].name, "_last"}, 256'(desc_data[7:0]),
                  256'(vecs[v].expLast));
      checkOutput({vecs[v].name, "_kp_id"}, 256'(desc_kp_id), 256'(vecs[v].kpId));
      checkWeight({vecs[v].name, "_weight"}, vecs[v].expWeight);
      tick();
      checkOutput({vecs[v].name, "_drained"}, 256'(desc_valid), 256'(0));
    end

    // Back-to-back: 96 beats, in_valid held, pulses 32/64/96 edges later
    for (int c = 0; c < 100; c++) begin
      checkOutput("b2b_valid", 256'(desc_valid),
                  256'((c == 32) || (c == 64) || (c == 96)));
      if (c < 96) checkOutput("b2b_in_ready", 256'(in_ready), 256'(1));
      if (c == 32 || c == 64 || c == 96) begin
        checkOutput("b2b_data", desc_data, buildDesc(8'((c / 32 - 1) * 32), 8'h01));
        checkOutput("b2b_kp_id", 256'(desc_kp_id), 256'(16'h0100 + 16'(c / 32 - 1)));
      end
      in_valid = (c < 96);
      in_bits  = 8'(c);
      in_kp_id = 16'h0100 + 16'(c / 32);
      tick();
    end
    in_valid = 1'b0;

    // Backpressure: A held, B fills then parks in HOLD
    desc_ready = 1'b0;
    descA = buildDesc(8'h10, 8'h01);
    descB = buildDesc(8'h20, 8'h03);
    sendDescriptor(8'h10, 8'h01, 16'h0A0A);
    checkOutput("bp_a_valid", 256'(desc_valid), 256'(1));
    checkOutput("bp_a_data", desc_data, descA);
    sendDescriptor(8'h20, 8'h03, 16'h0B0B);
    checkOutput("bp_hold_in_ready", 256'(in_ready), 256'(0));
    checkOutput("bp_hold_a_data", desc_data, descA);
    checkOutput("bp_hold_a_kp_id", 256'(desc_kp_id), 256'(16'h0A0A));
    tick();
    checkOutput("bp_hold2_in_ready", 256'(in_ready), 256'(0));
    checkOutput("bp_hold2_a_data", desc_data, descA);
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    checkOutput("bp_xfer_valid", 256'(desc_valid), 256'(1));
    checkOutput("bp_xfer_b_data", desc_data, descB);
    checkOutput("bp_xfer_b_kp_id", 256'(desc_kp_id), 256'(16'h0B0B));
    checkWeight("bp_xfer_b_weight", $countones(descB));
    checkOutput("bp_xfer_in_ready", 256'(in_ready), 256'(1));

    // Hold stability: B stalled while inputs toggle
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_bits  = 8'($urandom);
      in_kp_id = 16'($urandom);
      in_abort = ((i % 7) == 3);
      tick();
      checkOutput("stab_valid", 256'(desc_valid), 256'(1));
      checkOutput("stab_data", desc_data, descB);
      checkOutput("stab_kp_id", 256'(desc_kp_id), 256'(16'h0B0B));
      checkWeight("stab_weight", $countones(descB));
    end
    in_valid = 1'b0;
    in_abort = 1'b1;
    tick();
    in_abort = 1'b0;
    desc_ready = 1'b1;
    tick();
    checkOutput("stab_drained", 256'(desc_valid), 256'(0));

    // Abort with a coincident 0xAA beat
    for (int k = 0; k < 10; k++) applyStimulus(8'hFF, 16'h0001);
    in_valid = 1'b1; in_bits = 8'hAA; in_kp_id = 16'h0002; in_abort = 1'b1;
    tick();
    in_abort = 1'b0;
    in_valid = 1'b0;
    checkOutput("abort_no_desc", 256'(desc_valid), 256'(0));
    sendDescriptor(8'h0F, 8'h00, 16'h0003);
    checkOutput("abort_valid", 256'(desc_valid), 256'(1));
    checkOutput("abort_data", desc_data, {32{8'h0F}});
    checkOutput("abort_kp_id", 256'(desc_kp_id), 256'(16'h0003));
    checkWeight("abort_weight", 128);
    tick();

    // Reset mid-descriptor with a held descriptor in the output register
    desc_ready = 1'b0;
    sendDescriptor(8'h33, 8'h00, 16'h0C0C);
    checkOutput("rstmid_held_valid", 256'(desc_valid), 256'(1));
    for (int k = 0; k < 16; k++) applyStimulus(8'h55, 16'h0D0D);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checkOutput("rstmid_valid", 256'(desc_valid), 256'(0));
    checkOutput("rstmid_data", desc_data, 256'(0));
    rst_n = 1'b1;
    checkOutput("rstmid_in_ready", 256'(in_ready), 256'(1));
    desc_ready = 1'b1;
    sendDescriptor(8'h80, 8'h00, 16'h0E0E);
    checkOutput("rstmid_new_valid", 256'(desc_valid), 256'(1));
    checkOutput("rstmid_new_data", desc_data, {32{8'h80}});
    checkOutput("rstmid_new_kp_id", 256'(desc_kp_id), 256'(16'h0E0E));
    checkWeight("rstmid_new_weight", 32);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
